// File: rtl/adc_buf_pkg.sv
// Shared constants, bank-state encoding and width helpers for the ADC
// sample buffer.
package adc_buf_pkg;

    localparam logic MODE_FIFO = 1'b0;
    localparam logic MODE_PP   = 1'b1;

    typedef enum logic [1:0] {
        BK_FILL  = 2'd0,
        BK_READY = 2'd1,
        BK_DRAIN = 2'd2
    } bank_st_t;

    function automatic int addr_w(input int words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 2;
    endfunction

endpackage

// File: rtl/adc_buf_ram.sv
// Simple dual-port sample RAM: one write port, one registered read port.
// The read register clears on reset/clear; the array itself is never reset.
module adc_buf_ram
    import adc_buf_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int WORDS      = 2048,
    parameter int RAW        = addr_w(WORDS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  wr_en,
    input  logic [RAW-1:0]        wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [RAW-1:0]        rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [WORDS];

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_addr] <= wr_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rd_data <= '0;
        else if (clr)
            rd_data <= '0;
        else if (rd_en)
            rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/adc_pingpong_buffer.sv
// ADC sample buffer: continuous FIFO or two ping-pong banks handed over whole.
// Optional watermark output enabled by ADC_BUF_WATERMARK_EN.
module adc_pingpong_buffer
    import adc_buf_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 1024,
    parameter int AW         = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mode,
    input  logic                  clr,
    input  logic                  flush,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic [1:0]            bank_ready,
    output logic                  rd_bank,
    output logic [AW:0]           bank_len,
    output logic                  bank_done,
    output logic [AW+1:0]         count,
    output logic                  empty,
    output logic                  full,
    output logic                  overflow,
    input  logic [AW+1:0]         wm_level,
    output logic                  wm_hit
);

    localparam int CW = cnt_w(DEPTH);
    localparam logic [CW-1:0] CAP  = CW'(2 * DEPTH);
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    logic          pp;
    logic [CW-1:0] wr_ptr, wr_ptr_nxt;
    logic [CW-1:0] rd_ptr, rd_ptr_nxt;
    logic [CW-1:0] fcount, fcount_nxt;
    logic          wr_bank, wr_bank_nxt, rd_bank_nxt;
    bank_st_t      bst [2];
    bank_st_t      bst_nxt [2];
    logic [AW:0]   blen [2];
    logic [AW:0]   blen_nxt [2];
    logic          ovf_nxt, done_nxt, rv_nxt;
    logic [1:0]    rdy;
    logic          wr_ok, rd_ok, wr_last, rd_last, close;
    logic [AW:0]   close_len;
    logic [AW:0]   wr_addr, rd_addr;

    assign pp         = (mode == MODE_PP);
    assign rdy        = {bst[1] != BK_FILL, bst[0] != BK_FILL};
    assign bank_ready = rdy;
    assign bank_len   = blen[rd_bank];
    assign count      = pp ? wr_ptr : fcount;
    assign full       = pp ? rdy[wr_bank] : (fcount == CAP);
    assign empty      = pp ? !rdy[rd_bank] : (fcount == '0);

    assign wr_ok     = wr_en && !full && !clr;
    assign rd_ok     = rd_en && !empty && !clr;
    assign wr_last   = pp && wr_ok && (wr_ptr[AW-1:0] == LAST);
    assign close     = wr_last || (pp && flush && !clr && wr_ptr != '0);
    assign close_len = wr_ptr[AW:0] + {{AW{1'b0}}, wr_ok};
    assign rd_last   = pp && rd_ok && (rd_ptr[AW:0] == blen[rd_bank] - 1'b1);

    // ping-pong addresses are {bank, ptr}; FIFO uses the whole array
    assign wr_addr = pp ? {wr_bank, wr_ptr[AW-1:0]} : wr_ptr[AW:0];
    assign rd_addr = pp ? {rd_bank, rd_ptr[AW-1:0]} : rd_ptr[AW:0];

    always_comb begin
        wr_ptr_nxt  = wr_ptr;
        rd_ptr_nxt  = rd_ptr;
        fcount_nxt  = fcount;
        wr_bank_nxt = wr_bank;
        rd_bank_nxt = rd_bank;
        bst_nxt     = bst;
        blen_nxt    = blen;
        ovf_nxt     = overflow | (wr_en && full && !clr);
        done_nxt    = close;
        rv_nxt      = rd_ok;

        if (wr_ok)
            wr_ptr_nxt = wr_ptr + 1'b1;
        if (rd_ok)
            rd_ptr_nxt = rd_ptr + 1'b1;
        if (!pp)
            fcount_nxt = fcount + CW'(wr_ok) - CW'(rd_ok);

        if (close) begin
            bst_nxt[wr_bank]  = BK_READY;
            blen_nxt[wr_bank] = close_len;
            wr_bank_nxt       = !wr_bank;
            wr_ptr_nxt        = '0;
        end

        if (pp && rd_ok)
            bst_nxt[rd_bank] = BK_DRAIN;
        if (rd_last) begin
            bst_nxt[rd_bank]  = BK_FILL;
            blen_nxt[rd_bank] = '0;
            rd_bank_nxt       = !rd_bank;
            rd_ptr_nxt        = '0;
        end

        if (clr) begin
            wr_ptr_nxt  = '0;
            rd_ptr_nxt  = '0;
            fcount_nxt  = '0;
            wr_bank_nxt = 1'b0;
            rd_bank_nxt = 1'b0;
            bst_nxt[0]  = BK_FILL;
            bst_nxt[1]  = BK_FILL;
            blen_nxt[0] = '0;
            blen_nxt[1] = '0;
            ovf_nxt     = 1'b0;
            done_nxt    = 1'b0;
            rv_nxt      = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            fcount    <= '0;
            wr_bank   <= 1'b0;
            rd_bank   <= 1'b0;
            bst[0]    <= BK_FILL;
            bst[1]    <= BK_FILL;
            blen[0]   <= '0;
            blen[1]   <= '0;
            overflow  <= 1'b0;
            bank_done <= 1'b0;
            rd_valid  <= 1'b0;
        end else begin
            wr_ptr    <= wr_ptr_nxt;
            rd_ptr    <= rd_ptr_nxt;
            fcount    <= fcount_nxt;
            wr_bank   <= wr_bank_nxt;
            rd_bank   <= rd_bank_nxt;
            bst       <= bst_nxt;
            blen      <= blen_nxt;
            overflow  <= ovf_nxt;
            bank_done <= done_nxt;
            rd_valid  <= rv_nxt;
        end
    end

    adc_buf_ram #(
        .DATA_WIDTH(DATA_WIDTH),
        .WORDS     (2 * DEPTH),
        .RAW       (AW + 1)
    ) u_ram (
        .clk    (clk),
        .rst    (rst),
        .clr    (clr),
        .wr_en  (wr_ok),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .rd_en  (rd_ok),
        .rd_addr(rd_addr),
        .rd_data(rd_data)
    );

`ifdef ADC_BUF_WATERMARK_EN
    logic [CW-1:0] cnt_nxt;

    // computed from the next count so wm_hit lines up with count
    assign cnt_nxt = pp ? wr_ptr_nxt : fcount_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            wm_hit <= 1'b0;
        else
            wm_hit <= (wm_level != '0) && (cnt_nxt >= wm_level);
    end
`else
    logic unused_wm;

    assign unused_wm = ^wm_level;
    assign wm_hit    = 1'b0;
`endif

endmodule
